otter_pc_unit: RTL

Registered, parametrised program-counter unit for the Otter MCU, replacing the bare next-PC selector with a PC register, a pending-redirect buffer and target-alignment checking. It accepts the same six next-PC sources (sequential, jalr, branch, jal, mtvec, mepc) and holds redirects that arrive while the control FSM stalls PC writes. An optional return-address stack supplies predicted return targets. It sits between the control unit, branch-address generator and CSR file on one side and instruction memory on the other.

---
 rtl/otter_pc_pkg.sv | 39 +++
 rtl/otter_ras.sv | 65 ++++++
 rtl/otter_pc_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/otter_pc_pkg.sv
// Shared types and constants for the Otter program-counter unit.
// Next-PC source encoding, default geometry and source-classification helpers.
package otter_pc_pkg;

  localparam int          DEF_XLEN      = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam int          DEF_RAS_DEPTH = 4;

  // Next-PC source select; encodings 6 and 7 are illegal.
  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_JALR   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JAL    = 3'd3,
    SEL_MTVEC  = 3'd4,
    SEL_MEPC   = 3'd5
  } pc_sel_t;

  // Sources whose targets must be word aligned (trap vectors are trusted).
  function automatic logic is_checked_sel(input logic [2:0] sel);
    logic chk;
    case (sel)
      SEL_JALR, SEL_BRANCH, SEL_JAL: chk = 1'b1;
      default:                       chk = 1'b0;
    endcase
    return chk;
  endfunction

  // Sources that redirect the PC away from the sequential path.
  function automatic logic is_redirect_sel(input logic [2:0] sel);
    logic rdr;
    case (sel)
      SEL_JALR, SEL_BRANCH, SEL_JAL, SEL_MTVEC, SEL_MEPC: rdr = 1'b1;
      default:                                            rdr = 1'b0;
    endcase
    return rdr;
  endfunction

endpackage

// File: rtl/otter_ras.sv
// Circular return-address stack for the Otter PC unit.
// Overflow silently overwrites the oldest entry; popping an empty stack is a
// no-op. A simultaneous push and pop replaces the top without changing depth.
module otter_ras
  import otter_pc_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_r;      // next free slot
  logic [CNT_W-1:0] cnt_r;      // live entries, saturates at RAS_DEPTH
  logic [PTR_W-1:0] top_idx_s;
  logic             full_s;

  assign top_idx_s = ptr_r - PTR_W'(1'b1);
  assign full_s    = (cnt_r == CNT_W'(RAS_DEPTH));
  assign empty     = (cnt_r == '0);

  // Present the top entry, or zero when nothing is stored.
  always_comb begin
    top = '0;
    if (empty) begin
      top = '0;
    end else begin
      top = mem_r[top_idx_s];
    end
  end

  // Stack storage, pointer and depth update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      ptr_r <= '0;
      cnt_r <= '0;
    end else if (push && pop && !empty) begin
      mem_r[top_idx_s] <= push_data;
    end else if (push) begin
      mem_r[ptr_r] <= push_data;
      ptr_r        <= ptr_r + PTR_W'(1'b1);
      cnt_r        <= full_s ? cnt_r : cnt_r + CNT_W'(1'b1);
    end else if (pop && !empty) begin
      ptr_r <= top_idx_s;
      cnt_r <= cnt_r - CNT_W'(1'b1);
    end else begin
      ptr_r <= ptr_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/otter_pc_unit.sv
// Otter MCU program-counter unit: PC register, pending-redirect buffer held
// across PC-write stalls, target alignment checking and illegal-select
// reporting. Define OTTER_PC_RAS_EN to build in the return-address stack;
// without it ras_top reads 0, ras_empty reads 1 and call/ret are ignored.
module otter_pc_unit
  import otter_pc_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] jalr,
  input  logic [XLEN-1:0] branch,
  input  logic [XLEN-1:0] jal,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr,
  output logic            illegal_sel,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic [XLEN-1:0] pc_r;
  logic            pend_valid_r;
  logic [XLEN-1:0] pend_addr_r;
  logic            misalign_r;
  logic [XLEN-1:0] bad_addr_r;
  logic            illegal_r;

  logic [XLEN-1:0] target_s;
  logic            redirect_s;
  logic            seq_s;
  logic            misaligned_s;

  logic [XLEN-1:0] pc_nxt_s;
  logic            pend_valid_nxt_s;
  logic [XLEN-1:0] pend_addr_nxt_s;
  logic            misalign_nxt_s;
  logic [XLEN-1:0] bad_addr_nxt_s;
  logic            illegal_nxt_s;

  assign pc_plus4    = pc_r + PC_STEP;
  assign pc          = pc_r;
  assign misalign    = misalign_r;
  assign bad_addr    = bad_addr_r;
  assign illegal_sel = illegal_r;

  // Effective redirect target: jalr clears bit 0, mtvec is direct-mode only.
  always_comb begin
    target_s = '0;
    case (pc_sel)
      SEL_JALR:   target_s = {jalr[XLEN-1:1], 1'b0};
      SEL_BRANCH: target_s = branch;
      SEL_JAL:    target_s = jal;
      SEL_MTVEC:  target_s = {mtvec[XLEN-1:2], 2'b00};
      SEL_MEPC:   target_s = mepc;
      default:    target_s = '0;
    endcase
  end

  assign seq_s        = (pc_sel == SEL_SEQ);
  assign redirect_s   = is_redirect_sel(pc_sel);
  assign misaligned_s = redirect_s && is_checked_sel(pc_sel) && (target_s[1:0] != 2'b00);

  // Next PC, pending buffer and error-flag selection.
  always_comb begin
    pc_nxt_s         = pc_r;
    pend_valid_nxt_s = pend_valid_r;
    pend_addr_nxt_s  = pend_addr_r;
    misalign_nxt_s   = 1'b0;
    bad_addr_nxt_s   = bad_addr_r;
    illegal_nxt_s    = 1'b0;
    if (pc_write) begin
      if (seq_s) begin
        // A buffered redirect takes the place of the sequential step.
        pc_nxt_s         = pend_valid_r ? pend_addr_r : pc_plus4;
        pend_valid_nxt_s = 1'b0;
      end else if (redirect_s) begin
        // Any redirect, including traps, supersedes a buffered one.
        if (misaligned_s) begin
          misalign_nxt_s = 1'b1;
          bad_addr_nxt_s = target_s;
        end else begin
          pc_nxt_s = target_s;
        end
        pend_valid_nxt_s = 1'b0;
      end else begin
        illegal_nxt_s = 1'b1;
      end
    end else begin
      if (redirect_s) begin
        // Stalled: remember the newest good target, report bad ones now.
        if (misaligned_s) begin
          misalign_nxt_s = 1'b1;
          bad_addr_nxt_s = target_s;
        end else begin
          pend_valid_nxt_s = 1'b1;
          pend_addr_nxt_s  = target_s;
        end
      end else begin
        pend_valid_nxt_s = pend_valid_r;
      end
    end
  end

  // PC, pending-redirect and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r         <= RESET_VEC;
      pend_valid_r <= 1'b0;
      pend_addr_r  <= '0;
      misalign_r   <= 1'b0;
      bad_addr_r   <= '0;
      illegal_r    <= 1'b0;
    end else begin
      pc_r         <= pc_nxt_s;
      pend_valid_r <= pend_valid_nxt_s;
      pend_addr_r  <= pend_addr_nxt_s;
      misalign_r   <= misalign_nxt_s;
      bad_addr_r   <= bad_addr_nxt_s;
      illegal_r    <= illegal_nxt_s;
    end
  end

`ifdef OTTER_PC_RAS_EN
  logic ras_push_s;
  logic ras_pop_s;

  assign ras_push_s = call & pc_write;
  assign ras_pop_s  = ret & pc_write;

  otter_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras_hints_s;

  assign unused_ras_hints_s = call ^ ret;
  assign ras_top            = '0;
  assign ras_empty          = 1'b1;
`endif

endmodule
